// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-in, serial-out frame transmitter (start, WIDTH data bits, stop; DIV clocks per bit)
module serial_frame_tx #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             txd,
  output logic             busy,
  output logic             done
);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [DW-1:0]    div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             txd_q, txd_d;
  logic             tick, last_bit;
  always_comb begin
    tick     = div_q == DW'(DIV - 1);
    last_bit = bit_q == BW'(WIDTH - 1);
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    div_d    = tick ? '0 : div_q + 1'b1;
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (load) begin
          state_d = START;
          shift_d = din;
          bit_d   = '0;
        end
      end
      START: state_d = tick ? DATA : START;
      DATA: if (tick) begin
        shift_d = MSB_FIRST ? shift_q << 1 : shift_q >> 1;
        bit_d   = last_bit ? '0 : bit_q + 1'b1;
        state_d = last_bit ? STOP : DATA;
      end
      STOP: state_d = tick ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
    // txd is registered, so it is driven from the state/shift value taking effect at this edge
    txd_d = state_d == START ? 1'b0 :
            state_d == DATA  ? (MSB_FIRST ? shift_d[WIDTH-1] : shift_d[0]) : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= IDLE;
      shift_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      txd_q   <= txd_d;
    end
  end
  assign ready = state_q == IDLE;
  assign busy  = state_q != IDLE;
  assign done  = state_q == STOP && tick;
  assign txd   = txd_q;
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: scoreboard bench for serial_frame_tx in three configurations
module tb_serial_frame_tx;
  typedef struct {logic txd; logic done; logic busy;} exp_t;
  logic clk = 1'b0, clr = 1'b0, load_s = 1'b0;
  logic [7:0] din_s = 8'h00;
  int sel = 0, cyc = 0, checks = 0, failures = 0;
  logic ready_a, txd_a, busy_a, done_a;
  logic ready_b, txd_b, busy_b, done_b;
  logic ready_c, txd_c, busy_c, done_c;
  logic ready_s, txd_s, busy_s, done_s;
  exp_t exp_q[$];
  int acc_q[$];
  always #5 clk = ~clk;
  serial_frame_tx #(.WIDTH(8), .DIV(4), .MSB_FIRST(1'b0)) u_a (
    .clk(clk), .clr(clr), .din(din_s), .load(load_s && sel == 0),
    .ready(ready_a), .txd(txd_a), .busy(busy_a), .done(done_a));
  serial_frame_tx #(.WIDTH(8), .DIV(4), .MSB_FIRST(1'b1)) u_b (
    .clk(clk), .clr(clr), .din(din_s), .load(load_s && sel == 1),
    .ready(ready_b), .txd(txd_b), .busy(busy_b), .done(done_b));
  serial_frame_tx #(.WIDTH(4), .DIV(1), .MSB_FIRST(1'b0)) u_c (
    .clk(clk), .clr(clr), .din(din_s[3:0]), .load(load_s && sel == 2),
    .ready(ready_c), .txd(txd_c), .busy(busy_c), .done(done_c));
  always_comb begin
    ready_s = sel == 0 ? ready_a : sel == 1 ? ready_b : ready_c;
    txd_s   = sel == 0 ? txd_a   : sel == 1 ? txd_b   : txd_c;
    busy_s  = sel == 0 ? busy_a  : sel == 1 ? busy_b  : busy_c;
    done_s  = sel == 0 ? done_a  : sel == 1 ? done_b  : done_c;
  end
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clr && load_s && ready_s) acc_q.push_back(cyc);
  end
  task automatic push_frame(input logic [7:0] d);
    int w, dv;
    exp_t e;
    w  = sel == 2 ? 4 : 8;
    dv = sel == 2 ? 1 : 4;
    for (int s = 0; s < w + 2; s++)
      for (int j = 0; j < dv; j++) begin
        e.txd  = s == 0 ? 1'b0 : s == w + 1 ? 1'b1 : (sel == 1 ? d[w-s] : d[s-1]);
        e.done = s == w + 1 && j == dv - 1;
        e.busy = 1'b1;
        exp_q.push_back(e);
      end
  endtask
  task automatic push_idle();
    exp_t e;
    e.txd = 1'b1; e.done = 1'b0; e.busy = 1'b0;
    exp_q.push_back(e);
  endtask
  task automatic start_frame(input int s, input logic [7:0] d, input bit hold);
    @(negedge clk);
    sel = s;
    din_s = d;
    #1;
    checks++;
    if (ready_s !== 1'b1) begin
      failures++;
      $display("FAIL start_ready sel=%0d got=%b exp=1", s, ready_s);
    end
    load_s = 1'b1;
    push_frame(d);
    @(posedge clk);
    #1 if (!hold) load_s = 1'b0;
  endtask
  task automatic check_frame(input string name, input int at_a, input logic ld_a,
                             input logic [7:0] dn_a, input int at_b, input logic ld_b);
    int i;
    exp_t e;
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (txd_s !== e.txd) begin
        failures++;
        $display("FAIL %s txd cycle=%0d got=%b exp=%b", name, i + 1, txd_s, e.txd);
      end
      checks++;
      if (done_s !== e.done) begin
        failures++;
        $display("FAIL %s done cycle=%0d got=%b exp=%b", name, i + 1, done_s, e.done);
      end
      checks++;
      if (busy_s !== e.busy) begin
        failures++;
        $display("FAIL %s busy cycle=%0d got=%b exp=%b", name, i + 1, busy_s, e.busy);
      end
      checks++;
      if (ready_s !== !e.busy) begin
        failures++;
        $display("FAIL %s ready cycle=%0d got=%b exp=%b", name, i + 1, ready_s, !e.busy);
      end
      if (i == at_a) begin
        load_s = ld_a;
        din_s = dn_a;
      end
      if (i == at_b) load_s = ld_b;
      i++;
    end
  endtask
  task automatic check_idle(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if ({txd_s, busy_s, ready_s, done_s} !== 4'b1010) begin
        failures++;
        $display("FAIL %s idle cycle=%0d got txd/busy/ready/done=%b%b%b%b exp=1010",
                 name, i, txd_s, busy_s, ready_s, done_s);
      end
    end
  endtask
  task automatic test_reset();
    clr = 1'b0;
    repeat (2) @(posedge clk);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      sel = s;
      #1;
      checks++;
      if ({txd_s, busy_s, ready_s, done_s} !== 4'b1010) begin
        failures++;
        $display("FAIL reset sel=%0d got txd/busy/ready/done=%b%b%b%b exp=1010",
                 s, txd_s, busy_s, ready_s, done_s);
      end
    end
    @(negedge clk);
    clr = 1'b1;
  endtask
  task automatic test_lsb_first();
    start_frame(0, 8'hA5, 1'b0);
    check_frame("lsb_a5", -1, 1'b0, 8'h00, -1, 1'b0);
    check_idle("lsb_ready", 1);
  endtask
  task automatic test_msb_first();
    start_frame(1, 8'hA5, 1'b0);
    check_frame("msb_a5", -1, 1'b0, 8'h00, -1, 1'b0);
    check_idle("msb_ready", 1);
  endtask
  task automatic test_ignored_load();
    start_frame(0, 8'hA5, 1'b0);
    check_frame("busy_load", 10, 1'b1, 8'h3C, 11, 1'b0);
    check_idle("no_second_frame", 60);
  endtask
  task automatic test_back_to_back();
    int gap;
    acc_q.delete();
    start_frame(0, 8'hFF, 1'b1);
    push_idle();
    push_frame(8'h00);
    check_frame("hold_load", 19, 1'b1, 8'h00, 41, 1'b0);
    check_idle("hold_ready", 1);
    gap = acc_q.size() == 2 ? acc_q[1] - acc_q[0] : -1;
    checks++;
    if (acc_q.size() != 2 || gap != 41) begin
      failures++;
      $display("FAIL accept_gap got count=%0d gap=%0d exp count=2 gap=41", acc_q.size(), gap);
    end
  endtask
  task automatic test_reset_abort();
    start_frame(0, 8'hA5, 1'b0);
    repeat (15) @(negedge clk);
    clr = 1'b0;
    @(posedge clk);
    #1 clr = 1'b1;
    exp_q.delete();
    check_idle("abort", 60);
    start_frame(0, 8'h96, 1'b0);
    check_frame("after_abort", -1, 1'b0, 8'h00, -1, 1'b0);
    check_idle("after_abort_ready", 1);
  endtask
  task automatic test_div1();
    start_frame(2, 8'h06, 1'b0);
    check_frame("div1", -1, 1'b0, 8'h00, -1, 1'b0);
    check_idle("div1_ready", 1);
  endtask
  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_ignored_load();
    test_back_to_back();
    test_reset_abort();
    test_div1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
